// File: rtl/mem_loader_pkg.sv
// Shared definitions for the program-memory loader: state encoding and memory-map bounds.
package mem_loader_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    // Default writable window of program memory, shared with the ROM and memory map.
    localparam logic [ADDR_W-1:0] BOUND_L_DEF = 16'hc000;
    localparam logic [ADDR_W-1:0] BOUND_U_DEF = 16'hffff;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/mem_loader_range_chk.sv
// Combinational check that a load request is word-aligned and fits inside the writable window.
module mem_loader_range_chk
    import mem_loader_pkg::*;
#(
    parameter logic [15:0] BOUND_U = BOUND_U_DEF,
    parameter logic [15:0] BOUND_L = BOUND_L_DEF
) (
    input  logic [15:0] base_addr,
    input  logic [15:0] length,
    output logic        ok
);

    logic [16:0] last_addr;

    // Last byte address is formed in 17 bits so a load running past 16'hffff fails instead of wrapping.
    always_comb begin
        last_addr = {1'b0, base_addr} + {1'b0, length} - 17'd1;
        ok        = !base_addr[0]
                    && (base_addr >= BOUND_L)
                    && (last_addr <= {1'b0, BOUND_U});
    end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream to program-memory loader: packs little-endian bytes into 16-bit word writes.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [15:0] BOUND_U = BOUND_U_DEF,
    parameter logic [15:0] BOUND_L = BOUND_L_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] base_addr,
    input  logic [15:0] length,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    output logic        mem_bw,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state;
    logic [15:0] addr;
    logic [15:0] rem;
    logic [15:0] rem_dec;
    logic [7:0]  lo;
    logic        we_q;
    logic        bw_q;
    logic [15:0] wr_addr_q;
    logic [15:0] wr_din_q;
    logic        range_ok;

    mem_loader_range_chk #(
        .BOUND_U (BOUND_U),
        .BOUND_L (BOUND_L)
    ) u_range_chk (
        .base_addr (base_addr),
        .length    (length),
        .ok        (range_ok)
    );

    assign rem_dec = rem - 16'd1;

    // An abort landing on the write cycle must suppress that write, so the strobe is qualified here.
    assign mem_we   = we_q & ~abort;
    assign mem_addr = mem_we ? wr_addr_q : 16'h0000;
    assign mem_din  = mem_we ? wr_din_q  : 16'h0000;
    assign mem_bw   = mem_we ? bw_q      : 1'b0;

    // Loader FSM; each transition also sets the registered status and write-port outputs for the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= 16'h0000;
            rem       <= 16'h0000;
            lo        <= 8'h00;
            we_q      <= 1'b0;
            bw_q      <= 1'b0;
            wr_addr_q <= 16'h0000;
            wr_din_q  <= 16'h0000;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            bw_q      <= 1'b0;
            wr_addr_q <= 16'h0000;
            wr_din_q  <= 16'h0000;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr <= base_addr;
                        rem  <= length;
                        busy <= 1'b1;
                        if (length == 16'h0000) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (!range_ok) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else begin
                            state    <= ST_LO;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_LO: begin
                    if (abort) begin
                        state    <= ST_ERR;
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                    end else if (in_valid) begin
                        lo  <= in_byte;
                        rem <= rem_dec;
                        if (rem_dec == 16'h0000) begin
                            state     <= ST_WRITE;
                            in_ready  <= 1'b0;
                            we_q      <= 1'b1;
                            bw_q      <= 1'b1;
                            wr_addr_q <= addr;
                            wr_din_q  <= {8'h00, in_byte};
                        end else begin
                            state <= ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (abort) begin
                        state    <= ST_ERR;
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                    end else if (in_valid) begin
                        rem       <= rem_dec;
                        state     <= ST_WRITE;
                        in_ready  <= 1'b0;
                        we_q      <= 1'b1;
                        bw_q      <= 1'b0;
                        wr_addr_q <= addr;
                        wr_din_q  <= {in_byte, lo};
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                    end else begin
                        addr <= addr + 16'd2;
                        if (rem == 16'h0000) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_LO;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
Write-side counterpart to the program ROM. Accepts a byte stream over a valid/ready handshake and assembles little-endian 16-bit words (low byte at the even address, high byte at +1). It writes those words into program memory over a single-cycle write port, filling the image that the fetch path later reads. It sits between a boot/debug byte source and the program memory array.

Parameters:
BOUND_U, 16'hffff, highest writable byte address (inclusive)
BOUND_L, 16'hc000, lowest writable byte address (inclusive)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
abort  input  1  cancels an active load
base_addr  input  16  first byte address of the load; latched on accepted start
length  input  16  number of bytes to load; latched on accepted start
in_byte  input  8  stream data
in_valid  input  1  stream data valid
in_ready  output  1  loader can accept in_byte this cycle
mem_addr  output  16  word write address (always even)
mem_din  output  16  write data {high byte, low byte}
mem_we  output  1  write strobe, one cycle per word
mem_bw  output  1  1 = byte write (low byte only), 0 = word write
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on rejected start or abort

Behaviour:
- Reset: state IDLE; all outputs 0; internal addr, remaining count and byte latches cleared. Reset during a load drops it with no write and no done/err pulse.
- States: IDLE, LO, HI, WRITE, DONE, ERR.
- IDLE, start=1: latch addr=base_addr and rem=length.
  - Reject to ERR if base_addr is odd, base_addr < BOUND_L, or base_addr + length - 1 > BOUND_U. The bound is computed in 17 bits, so a load past 16'hffff is an error, not a wrap.
  - length==0 goes to DONE, with no range check and no write.
  - Otherwise go to LO.
- LO: in_ready=1. On in_valid, latch lo=in_byte and decrement rem. If the new rem is 0, go to WRITE with bw=1; else go to HI.
- HI: in_ready=1. On in_valid, latch hi=in_byte, decrement rem, go to WRITE with bw=0.
- WRITE: in_ready=0 and mem_we=1 for exactly one cycle.
  - mem_addr=addr.
  - mem_din={hi,lo} when mem_bw=0, {8'h00,lo} when mem_bw=1.
  - Next cycle: addr += 2. Go to DONE if rem==0, else LO.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE.
- mem_addr, mem_din and mem_bw are 0 whenever mem_we=0.
- start while busy: ignored.
- abort in LO/HI/WRITE: go to ERR; no mem_we in the abort cycle; a partially captured word is discarded. abort in IDLE, DONE or ERR: ignored. abort and in_valid in the same cycle: abort wins, byte not accepted.
- Throughput: at most one byte per cycle in LO/HI, then one WRITE bubble. Best case is 3 cycles per word.
- Latency: last byte accepted -> mem_we on the next cycle -> done on the cycle after that.

Decomposition:
- Shared package: state encoding (IDLE..ERR, 3 bits) and the default bound constants 16'hc000/16'hffff, shared with the ROM and memory map.
- Optional sub-module: mem_loader_range_chk, combinational base/length/alignment check returning ok. Everything else stays in one FSM module.

Test Plan:
- start, base=16'hc000, len=4, bytes 34,12,78,56 back-to-back -> mem_we at c000 din=1234 bw=0, then c002 din=5678 bw=0; done 1 cycle after the 2nd write; busy low after.
- start, base=16'hc010, len=3, bytes AA,BB,CC -> writes c010=BBAA bw=0, then c012=00CC bw=1; done pulse.
- Rejected starts, each -> err pulse, no mem_we: base=16'hc001 (odd); base=16'hbffe (below BOUND_L); base=16'hfffe len=3 (past BOUND_U).
- start base=16'hfffe len=2, in_valid toggling 1,0,0,1 -> in_ready high while waiting; single write fffe at the correct data; rem/addr unaffected by stall cycles.
- Abort after the 1st byte of a word -> err pulse, no write; new start base=c000 len=2 -> clean write to c000.
- rst asserted in HI -> next cycle busy=0, in_ready=0, mem_we=0, no done/err; len=0 start -> done pulse only.
